softmax_row_stream: RTL and testbench

Row-wise fixed-point softmax stage placed directly downstream of the MAC/bias matrix-multiply stage. It consumes the MAC result one row at a time as a stream of signed elements and buffers the whole row. It then computes a max-subtracted base-2 exponential approximation per element, accumulates the row sum, and emits each normalised probability as a signed 8-bit value in the range 0..127.

---
 rtl/softmax_row_stream.sv | 143 ++++++++++++++
 tb/tb_softmax_row_stream.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/softmax_row_stream.sv
// Row-wise fixed-point softmax: buffers one row, replaces each element with a
// base-2 exponential of (max - x), then normalises each entry to 0..127 with a serial divider.
module softmax_row_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 3072,
  parameter int SUM_WIDTH  = 8 + $clog2(ROW_LEN)
) (
  input  logic                         clk_p,
  input  logic                         rst_p,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int ADDR_W = $clog2(ROW_LEN);
  localparam int CNT_W  = $clog2(ROW_LEN + 1);
  localparam int DSH_W  = SUM_WIDTH + 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ROW_LEN);

  typedef enum logic [1:0] {LOAD, EXP, DIV} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0]             cnt;
  logic [DATA_WIDTH-1:0]        row_buf [ROW_LEN];
  logic [ADDR_W-1:0]            rd_addr;
  logic [DATA_WIDTH-1:0]        rd_data_p1;
  logic [ADDR_W-1:0]            wr_addr_p1;
  logic                         vld_p1;
  logic signed [DATA_WIDTH-1:0] row_max;
  logic signed [DATA_WIDTH:0]   dist_p1;
  logic [7:0]                   e_p1;
  logic [SUM_WIDTH-1:0]         sum;
  logic                         div_first, div_load, in_fire, out_fire;
  logic [2:0]                   step;
  logic [DSH_W-1:0]             rem, dsh;
  logic [6:0]                   q;

  // e(d) = F[d%4] >> (d/4); anything 32 or more below the max underflows to zero.
  function automatic logic [7:0] exp2_approx(input logic [DATA_WIDTH:0] d);
    logic [7:0] f;
    case (d[1:0])
      2'd0:    f = 8'd255;
      2'd1:    f = 8'd214;
      2'd2:    f = 8'd180;
      default: f = 8'd152;
    endcase
    if (d >= (DATA_WIDTH + 1)'(32)) return 8'd0;
    return f >> d[4:2];
  endfunction

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && cnt == LAST)  state_next = EXP;
      EXP:     if (cnt == FULL)             state_next = DIV;
      DIV:     if (out_fire && cnt == LAST) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // DIV reads ahead by one slot so the next dividend is ready on the handshake cycle.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    busy     = !(state == LOAD && cnt == '0);
    div_load = (state == DIV) && (div_first || (out_fire && cnt != LAST));
    rd_addr  = '0;
    if (state == EXP && cnt != FULL)      rd_addr = ADDR_W'(cnt);
    else if (state == DIV && cnt != LAST) rd_addr = ADDR_W'(cnt + CNT_W'(1));
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      cnt       <= '0;
      in_ready  <= 1'b0;
      vld_p1    <= 1'b0;
      div_first <= 1'b0;
      step      <= '0;
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == LOAD);
      vld_p1    <= (state == EXP) && (cnt != FULL);
      div_first <= (state == EXP) && (cnt == FULL);
      case (state)
        LOAD:    if (in_fire)  cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        EXP:     cnt <= (cnt == FULL) ? '0 : cnt + CNT_W'(1);
        DIV:     if (out_fire) cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        default: cnt <= '0;
      endcase
      if (div_load) begin
        step <= 3'd7;
        q    <= '0;
      end else if (step != '0) begin
        q    <= {q[5:0], rem >= dsh};
        step <= step - 3'd1;
      end
      if (out_fire)          out_valid <= 1'b0;
      else if (step == 3'd1) out_valid <= 1'b1;
    end
  end

  // p0 -> p1: synchronous buffer read; p1 computes e and writes it back in place.
  assign dist_p1 = $signed({row_max[DATA_WIDTH-1], row_max})
                 - $signed({rd_data_p1[DATA_WIDTH-1], rd_data_p1});
  assign e_p1    = exp2_approx($unsigned(dist_p1));

  always_ff @(posedge clk_p) begin
    rd_data_p1 <= row_buf[rd_addr];
    wr_addr_p1 <= ADDR_W'(cnt);
    if (in_fire) begin
      row_buf[ADDR_W'(cnt)] <= in_data;
      if (cnt == '0 || in_data > row_max) row_max <= in_data;
    end else if (vld_p1) begin
      row_buf[wr_addr_p1] <= DATA_WIDTH'(e_p1);
    end
    if (state == LOAD) sum <= '0;
    else if (vld_p1)   sum <= sum + SUM_WIDTH'(e_p1);
    // Restoring divide of e*127 by sum: divisor starts at sum<<6 and halves each step.
    if (div_load) begin
      rem <= DSH_W'(rd_data_p1[7:0]) * DSH_W'(127);
      dsh <= DSH_W'(sum) << 6;
    end else if (step != '0) begin
      if (rem >= dsh) rem <= rem - dsh;
      dsh <= dsh >> 1;
    end
  end

  assign out_data = DATA_WIDTH'(q);
  assign out_last = out_valid && (cnt == LAST);

endmodule

// File: tb/tb_softmax_row_stream.sv
// Directed bench for softmax_row_stream with ROW_LEN=4: hand-computed rows,
// output latency, backpressure hold and reset in the middle of a row.
module tb_softmax_row_stream;
  localparam int DW = 8;
  localparam int RL = 4;

  logic clk_p = 1'b0;
  logic rst_p, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic signed [DW-1:0] in_data, out_data;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_p = ~clk_p;

  softmax_row_stream #(.DATA_WIDTH(DW), .ROW_LEN(RL)) dut (
    .clk_p(clk_p), .rst_p(rst_p),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int x);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = 8'(x);
    forever begin
      @(negedge clk_p);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk_p);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_row(input int a, input int b, input int c, input int d);
    push(a);
    check("busy_loading", int'(busy), 1);
    push(b);
    push(c);
    push(d);
  endtask

  task automatic recv_row(input string tag, input int q0, input int q1,
                          input int q2, input int q3, input int hold);
    int exp_q [4];
    exp_q = '{q0, q1, q2, q3};
    for (int i = 0; i < RL; i++) begin
      int n;
      n = 0;
      out_ready = (i != hold);
      do begin
        @(negedge clk_p);
        n++;
      end while (!out_valid && n < 200);
      if (!out_valid) begin
        check($sformatf("%s_timeout%0d", tag, i), 0, 1);
        out_ready = 1'b1;
        return;
      end
      check($sformatf("%s_lat%0d", tag, i), n, (i == 0) ? RL + 1 + 8 + 1 : 8);
      check($sformatf("%s_data%0d", tag, i), int'(out_data), exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), int'(out_last), (i == RL - 1) ? 1 : 0);
      check($sformatf("%s_inrdy%0d", tag, i), int'(in_ready), 0);
      if (i == hold) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk_p);
          check($sformatf("%s_hold_valid%0d", tag, k), int'(out_valid), 1);
          check($sformatf("%s_hold_data%0d", tag, k), int'(out_data), exp_q[i]);
          check($sformatf("%s_hold_last%0d", tag, k), int'(out_last), 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk_p);
      #1;
      check($sformatf("%s_drop%0d", tag, i), int'(out_valid), 0);
    end
    check($sformatf("%s_inrdy_back", tag), int'(in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"},  int'(out_data),  0);
    check({tag, "_out_last"},  int'(out_last),  0);
    check({tag, "_busy"},      int'(busy),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_p     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk_p);
    #1;
    check_reset_outputs("rst");
    rst_p = 1'b0;
    @(posedge clk_p);
    #1;
    check("ready_after_rst", int'(in_ready), 1);

    push_row(10, 10, 10, 10);
    recv_row("equal", 31, 31, 31, 31, -1);
    push_row(0, -4, -8, 127);
    recv_row("peak", 0, 0, 0, 127, -1);
    push_row(4, 0, 1, 2);
    recv_row("mix", 45, 22, 27, 32, -1);
    push_row(-128, 127, -128, 127);
    recv_row("extreme", 0, 63, 0, 63, -1);

    // Stall element 1, then run a second row straight after.
    push_row(4, 0, 1, 2);
    recv_row("bp", 45, 22, 27, 32, 1);
    push_row(10, 10, 10, 10);
    recv_row("b2b", 31, 31, 31, 31, -1);

    // Abort a half-loaded row.
    push(100);
    push(-50);
    check("busy_partial", int'(busy), 1);
    rst_p = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk_p);
    #1;
    rst_p = 1'b0;
    push_row(4, 0, 1, 2);
    recv_row("post_rst", 45, 22, 27, 32, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
